// File: rtl/sincronia_vga.sv
// ============================================================================
//  Module   : sincronia_vga
//  Brief    : VGA vertical timing and sync generation driven by the
//             horizontal pixel count; registered sync, blanking and strobes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sincronia_vga #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_TOTAL   = 800,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_TOTAL   = 525,
   parameter int SYNC_POL  = 0
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [9:0] cuenta,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic [9:0] cuenta_v,
   output logic [1:0] fase_v,
   output logic       fin_linea,
   output logic       fin_cuadro
);

   localparam logic [1:0] S_VISIBLE = 2'd0;
   localparam logic [1:0] S_FRONT   = 2'd1;
   localparam logic [1:0] S_SYNC    = 2'd2;
   localparam logic [1:0] S_BACK    = 2'd3;

   localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] C_H_SYNC_INI = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] C_H_SYNC_FIN = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_V_FRONT    = 10'(V_VISIBLE);
   localparam logic [9:0] C_V_SYNC     = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] C_V_BACK     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       C_ACT        = (SYNC_POL != 0);

   logic [1:0] r_fase, w_fase_sig;
   logic [9:0] r_cuenta_v, w_cuenta_v_sig, w_cuenta_v_inc;
   logic       w_fin_linea;

   logic       w_hsync, w_vsync, w_video_on, w_fin_cuadro;
   logic [9:0] w_pixel_x, w_pixel_y;

   logic       r_hsync, r_vsync, r_video_on, r_fin_linea, r_fin_cuadro;
   logic [9:0] r_pixel_x, r_pixel_y;

   // State register: line counter and vertical phase
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_fase     <= S_VISIBLE;
         r_cuenta_v <= '0;
      end else begin
         r_fase     <= w_fase_sig;
         r_cuenta_v <= w_cuenta_v_sig;
      end
   end

   // Next state: phase transitions keyed on the line number being entered
   always_comb begin
      w_fin_linea    = (cuenta == C_H_LAST);
      w_cuenta_v_inc = (r_cuenta_v == C_V_LAST) ? 10'd0 : r_cuenta_v + 10'd1;
      w_cuenta_v_sig = r_cuenta_v;
      w_fase_sig     = r_fase;
      if (w_fin_linea) begin
         w_cuenta_v_sig = w_cuenta_v_inc;
         case (r_fase)
            S_VISIBLE: if (w_cuenta_v_inc == C_V_FRONT) w_fase_sig = S_FRONT;
            S_FRONT:   if (w_cuenta_v_inc == C_V_SYNC)  w_fase_sig = S_SYNC;
            S_SYNC:    if (w_cuenta_v_inc == C_V_BACK)  w_fase_sig = S_BACK;
            S_BACK:    if (w_cuenta_v_inc == 10'd0)     w_fase_sig = S_VISIBLE;
            default:   w_fase_sig = S_VISIBLE;
         endcase
      end
   end

   // Outputs from the sampled count and the pre-update vertical state
   always_comb begin
      w_hsync      = ((cuenta >= C_H_SYNC_INI) && (cuenta < C_H_SYNC_FIN)) ? C_ACT : ~C_ACT;
      w_vsync      = (r_fase == S_SYNC) ? C_ACT : ~C_ACT;
      w_video_on   = (cuenta < C_H_VIS) && (r_fase == S_VISIBLE);
      w_pixel_x    = w_video_on ? cuenta : 10'd0;
      w_pixel_y    = w_video_on ? r_cuenta_v : 10'd0;
      w_fin_cuadro = w_fin_linea && (r_cuenta_v == C_V_LAST);
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_hsync      <= ~C_ACT;
         r_vsync      <= ~C_ACT;
         r_video_on   <= 1'b0;
         r_pixel_x    <= '0;
         r_pixel_y    <= '0;
         r_fin_linea  <= 1'b0;
         r_fin_cuadro <= 1'b0;
      end else begin
         r_hsync      <= w_hsync;
         r_vsync      <= w_vsync;
         r_video_on   <= w_video_on;
         r_pixel_x    <= w_pixel_x;
         r_pixel_y    <= w_pixel_y;
         r_fin_linea  <= w_fin_linea;
         r_fin_cuadro <= w_fin_cuadro;
      end
   end

   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign video_on   = r_video_on;
   assign pixel_x    = r_pixel_x;
   assign pixel_y    = r_pixel_y;
   assign cuenta_v   = r_cuenta_v;
   assign fase_v     = r_fase;
   assign fin_linea  = r_fin_linea;
   assign fin_cuadro = r_fin_cuadro;

endmodule

`default_nettype wire

// File: tb/tb_sincronia_vga.sv
// ============================================================================
//  Module   : tb_sincronia_vga
//  Brief    : Directed self-checking bench for sincronia_vga.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sincronia_vga;

   logic       Clk;
   logic       reset;
   logic [9:0] cuenta;
   logic       hsync, vsync, video_on, fin_linea, fin_cuadro;
   logic [9:0] pixel_x, pixel_y, cuenta_v;
   logic [1:0] fase_v;

   int total = 0;
   int bad   = 0;
   int mv    = 0;

   sincronia_vga dut (
      .Clk        (Clk),
      .reset      (reset),
      .cuenta     (cuenta),
      .hsync      (hsync),
      .vsync      (vsync),
      .video_on   (video_on),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .cuenta_v   (cuenta_v),
      .fase_v     (fase_v),
      .fin_linea  (fin_linea),
      .fin_cuadro (fin_cuadro)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fase_de(input int v);
      if (v < 480)      return 0;
      else if (v < 490) return 1;
      else if (v < 492) return 2;
      else              return 3;
   endfunction

   // Phase must always agree with the line range
   always @(negedge Clk) check("fase_inv", int'(fase_v), fase_de(int'(cuenta_v)));

   task automatic step(input int h);
      int vis;
      @(negedge Clk);
      cuenta = 10'(h);
      @(posedge Clk);
      #1;
      vis = (h < 640 && mv < 480) ? 1 : 0;
      check("hsync",      int'(hsync),      (h >= 656 && h < 752) ? 0 : 1);
      check("vsync",      int'(vsync),      (mv >= 490 && mv < 492) ? 0 : 1);
      check("video_on",   int'(video_on),   vis);
      check("pixel_x",    int'(pixel_x),    (vis != 0) ? h : 0);
      check("pixel_y",    int'(pixel_y),    (vis != 0) ? mv : 0);
      check("fin_linea",  int'(fin_linea),  (h == 799) ? 1 : 0);
      check("fin_cuadro", int'(fin_cuadro), (h == 799 && mv == 524) ? 1 : 0);
      if (h == 799) mv = (mv == 524) ? 0 : mv + 1;
      check("cuenta_v",   int'(cuenta_v),   mv);
      check("fase_v",     int'(fase_v),     fase_de(mv));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_hsync"},    int'(hsync),      1);
      check({tag, "_vsync"},    int'(vsync),      1);
      check({tag, "_video_on"}, int'(video_on),   0);
      check({tag, "_pixel_x"},  int'(pixel_x),    0);
      check({tag, "_pixel_y"},  int'(pixel_y),    0);
      check({tag, "_cuenta_v"}, int'(cuenta_v),   0);
      check({tag, "_fase_v"},   int'(fase_v),     0);
      check({tag, "_fin_lin"},  int'(fin_linea),  0);
      check({tag, "_fin_cua"},  int'(fin_cuadro), 0);
   endtask

   initial begin
      reset  = 1'b0;
      cuenta = 10'd700;

      // Reset held with clocks running
      repeat (3) @(posedge Clk);
      #1;
      check_reset_state("rst");
      @(negedge Clk);
      reset = 1'b1;
      mv = 0;

      // One full horizontal sweep on line 0
      for (int h = 0; h < 800; h++) step(h);
      check("sweep_line", int'(cuenta_v), 1);

      // Vertical phases: three samples per line up to line 524
      while (mv != 524) begin
         step(0);
         step(700);
         step(799);
         if (mv == 480) check("fase_480", int'(fase_v), 1);
         if (mv == 490) check("fase_490", int'(fase_v), 2);
         if (mv == 492) check("fase_492", int'(fase_v), 3);
      end
      step(10);
      check("l524_video", int'(video_on), 0);

      // Frame wrap
      step(799);
      check("wrap_fin_cuadro", int'(fin_cuadro), 1);
      check("wrap_fin_linea",  int'(fin_linea),  1);
      check("wrap_cuenta_v",   int'(cuenta_v),   0);
      check("wrap_fase_v",     int'(fase_v),     0);
      step(20);
      check("l0_video", int'(video_on), 1);
      check("l0_px",    int'(pixel_x),  20);

      // Out-of-range input on line 100
      repeat (100) step(799);
      for (int i = 0; i < 3; i++) begin
         step(800);
         check("oor_video",    int'(video_on),  0);
         check("oor_hsync",    int'(hsync),     1);
         check("oor_fin",      int'(fin_linea), 0);
         check("oor_cuenta_v", int'(cuenta_v),  100);
      end

      // Asynchronous reset between edges on line 300
      repeat (200) step(799);
      step(100);
      check("l300_py", int'(pixel_y), 300);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("async");
      mv = 0;
      repeat (2) @(negedge Clk);
      reset = 1'b1;
      step(5);
      check("post_video", int'(video_on), 1);
      check("post_py",    int'(pixel_y),  0);
      step(799);
      step(3);
      check("post_py_l1", int'(pixel_y),  1);
      check("post_px_l1", int'(pixel_x),  3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
